// File: rtl/ppu_scanline_sequencer.sv
// Scanline/frame sequencer for the PPU: walks PRE/VIS/POST/VBL lines, issues per-line
// render requests with a done handshake, and maintains vblank, NMI, frame parity and underrun.
module ppu_scanline_sequencer #(
  parameter int VISIBLE_LINES = 240,
  parameter int POST_LINES    = 1,
  parameter int VBLANK_LINES  = 20,
  parameter int LINE_W        = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              line_tick,
  input  logic              line_done,
  input  logic              render_en,
  input  logic              nmi_en,
  input  logic              status_rd,
  output logic              render_start,
  output logic [LINE_W-1:0] y_idx,
  output logic [2:0]        phase,
  output logic              vblank_flag,
  output logic              nmi,
  output logic              frame_odd,
  output logic              underrun
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_VIS  = 3'd2,
    ST_POST = 3'd3,
    ST_VBL  = 3'd4
  } state_t;

  localparam logic [LINE_W-1:0] Y_LAST    = LINE_W'(VISIBLE_LINES - 1);
  localparam logic [LINE_W-1:0] POST_LAST = LINE_W'(POST_LINES - 1);
  localparam logic [LINE_W-1:0] VBL_LAST  = LINE_W'(VBLANK_LINES - 1);

  state_t            state_q, state_d;
  logic [LINE_W-1:0] y_q, y_d;
  logic [LINE_W-1:0] cnt_q, cnt_d;
  logic              render_start_q, render_start_d;
  logic              pending_q, pending_d;
  logic              vblank_q, vblank_d;
  logic              nmi_q, nmi_d;
  logic              odd_q, odd_d;
  logic              underrun_q, underrun_d;

  always_comb begin
    state_d        = state_q;
    y_d            = y_q;
    cnt_d          = cnt_q;
    render_start_d = 1'b0;
    pending_d      = pending_q;
    vblank_d       = vblank_q;
    odd_d          = odd_q;
    underrun_d     = underrun_q;

    // Clears first so that any same-cycle set below takes precedence.
    if (status_rd) begin
      vblank_d   = 1'b0;
      underrun_d = 1'b0;
    end
    if (line_done) pending_d = 1'b0;

    if (frame_start && (state_q != ST_IDLE)) begin
      state_d   = ST_PRE;
      odd_d     = ~odd_q;
      cnt_d     = '0;
      y_d       = '0;
      pending_d = 1'b0;
      vblank_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_d  = ST_PRE;
            vblank_d = 1'b0;
          end
        end
        ST_PRE: begin
          if (line_tick) begin
            state_d        = ST_VIS;
            y_d            = '0;
            render_start_d = render_en;
          end
        end
        ST_VIS: begin
          if (line_tick) begin
            // A done arriving with the tick still meets the deadline.
            if (pending_q && !line_done) underrun_d = 1'b1;
            if (y_q == Y_LAST) begin
              state_d = ST_POST;
              y_d     = '0;
              cnt_d   = '0;
            end else begin
              y_d            = y_q + 1'b1;
              render_start_d = render_en;
            end
          end
        end
        ST_POST: begin
          if (line_tick) begin
            if (cnt_q == POST_LAST) begin
              state_d  = ST_VBL;
              vblank_d = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_VBL: begin
          if (line_tick) begin
            if (cnt_q == VBL_LAST) begin
              state_d  = ST_PRE;
              odd_d    = ~odd_q;
              cnt_d    = '0;
              vblank_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (render_start_d) pending_d = 1'b1;
    nmi_d = vblank_d & nmi_en;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      y_q            <= '0;
      cnt_q          <= '0;
      render_start_q <= 1'b0;
      pending_q      <= 1'b0;
      vblank_q       <= 1'b0;
      nmi_q          <= 1'b0;
      odd_q          <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      y_q            <= y_d;
      cnt_q          <= cnt_d;
      render_start_q <= render_start_d;
      pending_q      <= pending_d;
      vblank_q       <= vblank_d;
      nmi_q          <= nmi_d;
      odd_q          <= odd_d;
      underrun_q     <= underrun_d;
    end
  end

  assign render_start = render_start_q;
  assign y_idx        = y_q;
  assign phase        = state_q;
  assign vblank_flag  = vblank_q;
  assign nmi          = nmi_q;
  assign frame_odd    = odd_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_ppu_scanline_sequencer.sv
// Directed bench for ppu_scanline_sequencer with a 4/1/2 line frame and hand-derived expectations.
module tb_ppu_scanline_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start, line_tick, line_done, render_en, nmi_en, status_rd;
  logic       render_start;
  logic [8:0] y_idx;
  logic [2:0] phase;
  logic       vblank_flag, nmi, frame_odd, underrun;

  int checks = 0;
  int errors = 0;
  int exp_vb, exp_ur, exp_odd;
  int exp_ph [8] = '{2, 2, 2, 2, 3, 4, 4, 1};

  ppu_scanline_sequencer #(
    .VISIBLE_LINES(4),
    .POST_LINES   (1),
    .VBLANK_LINES (2),
    .LINE_W       (9)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .line_tick   (line_tick),
    .line_done   (line_done),
    .render_en   (render_en),
    .nmi_en      (nmi_en),
    .status_rd   (status_rd),
    .render_start(render_start),
    .y_idx       (y_idx),
    .phase       (phase),
    .vblank_flag (vblank_flag),
    .nmi         (nmi),
    .frame_odd   (frame_odd),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Ticks i in [from,to) of a frame starting from PRE; wh withholds line 2's done.
  task automatic run_ticks(input int from, input int to, input bit wh, input bit ren,
                           input int rd_at);
    int pulses = 0;
    int exp_pulses = 0;
    for (int i = from; i < to; i++) begin
      render_en = ren;
      line_tick = 1'b1;
      if (i == rd_at) status_rd = 1'b1;
      cyc();
      line_tick = 1'b0;
      status_rd = 1'b0;
      if (i == rd_at) begin
        exp_vb = 0;
        exp_ur = 0;
      end
      if (i == 5) exp_vb = 1;
      if (i == 7) begin
        exp_vb  = 0;
        exp_odd = exp_odd ^ 1;
      end
      if (wh && i == 3) exp_ur = 1;
      if (ren && i < 4) exp_pulses++;
      chk($sformatf("phase t%0d", i), phase, exp_ph[i]);
      chk($sformatf("y_idx t%0d", i), y_idx, (i < 4) ? i : 0);
      chk($sformatf("rstart t%0d", i), render_start, (ren && i < 4) ? 1 : 0);
      chk($sformatf("vblank t%0d", i), vblank_flag, exp_vb);
      chk($sformatf("nmi t%0d", i), nmi, exp_vb & int'(nmi_en));
      chk($sformatf("underrun t%0d", i), underrun, exp_ur);
      chk($sformatf("odd t%0d", i), frame_odd, exp_odd);
      if (render_start) pulses++;
      for (int j = 0; j < 9; j++) begin
        if (j == 2 && ren && i < 4 && !(wh && i == 2)) line_done = 1'b1;
        cyc();
        line_done = 1'b0;
        if (render_start) pulses++;
      end
    end
    chk("rstart count", pulses, exp_pulses);
  endtask

  initial begin
    int rs_seen;
    reset = 1'b0; frame_start = 1'b0; line_tick = 1'b0; line_done = 1'b0;
    render_en = 1'b1; nmi_en = 1'b0; status_rd = 1'b0;
    exp_vb = 0; exp_ur = 0; exp_odd = 0;
    cyc(); cyc();
    chk("rst phase", phase, 0);
    chk("rst rstart", render_start, 0);
    chk("rst vblank", vblank_flag, 0);
    chk("rst odd", frame_odd, 0);
    reset = 1'b1;
    cyc();

    // IDLE ignores line_tick
    line_tick = 1'b1; cyc(); line_tick = 1'b0;
    chk("idle tick phase", phase, 0);
    chk("idle tick rstart", render_start, 0);

    // Frame 1: normal render
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    chk("first pre phase", phase, 1);
    chk("first pre odd", frame_odd, 0);
    run_ticks(0, 8, 1'b0, 1'b1, -1);

    // Frame 2: line 2 done withheld, status read in VBL
    run_ticks(0, 6, 1'b1, 1'b1, -1);
    status_rd = 1'b1; cyc(); status_rd = 1'b0;
    exp_vb = 0; exp_ur = 0;
    chk("rd underrun", underrun, 0);
    chk("rd vblank", vblank_flag, 0);
    run_ticks(6, 8, 1'b0, 1'b1, -1);

    // Frame 3: rendering disabled
    run_ticks(0, 8, 1'b0, 1'b0, -1);

    // Frame 4: nmi_en raised mid-VBL, then status read
    run_ticks(0, 6, 1'b0, 1'b1, -1);
    chk("nmi masked", nmi, 0);
    nmi_en = 1'b1; cyc();
    chk("nmi rise", nmi, 1);
    status_rd = 1'b1; cyc(); status_rd = 1'b0;
    exp_vb = 0;
    chk("nmi fall", nmi, 0);
    chk("nmi fall vblank", vblank_flag, 0);
    run_ticks(6, 8, 1'b0, 1'b1, -1);

    // Resync with same-cycle tick at y_idx=2, line 2 still pending
    run_ticks(0, 3, 1'b1, 1'b1, -1);
    frame_start = 1'b1; line_tick = 1'b1; cyc();
    frame_start = 1'b0; line_tick = 1'b0;
    exp_odd = exp_odd ^ 1;
    chk("resync phase", phase, 1);
    chk("resync y_idx", y_idx, 0);
    chk("resync odd", frame_odd, exp_odd);
    chk("resync underrun", underrun, 0);
    rs_seen = int'(render_start);
    for (int k = 0; k < 4; k++) begin
      cyc();
      rs_seen += int'(render_start);
    end
    chk("resync rstart", rs_seen, 0);
    chk("resync hold phase", phase, 1);

    // Underrun again, then reset mid-frame
    run_ticks(0, 4, 1'b1, 1'b1, -1);
    reset = 1'b0; cyc(); reset = 1'b1;
    exp_vb = 0; exp_ur = 0; exp_odd = 0;
    chk("rst2 phase", phase, 0);
    chk("rst2 y_idx", y_idx, 0);
    chk("rst2 underrun", underrun, 0);
    chk("rst2 odd", frame_odd, 0);
    chk("rst2 nmi", nmi, 0);
    chk("rst2 rstart", render_start, 0);

    // Status read coincident with the vblank set
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    chk("restart phase", phase, 1);
    run_ticks(0, 8, 1'b0, 1'b1, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_scanline_sequencer.md
Name: ppu_scanline_sequencer

Overview:
Parametrised scanline/frame sequencer for the PPU. It replaces the fixed IDLE/RENDER/VBLANK scanline logic in the PPU top level. Driven by a per-line timing tick and a frame-start pulse from the VGA timing side, it walks pre-render, visible, post-render and vblank lines, and issues per-line render requests to the background/sprite renderer with a completion handshake. It also produces the vblank status flag, the NMI level, even/odd frame tracking and a sticky renderer-underrun flag.

Parameters:
VISIBLE_LINES, 240, number of rendered scanlines per frame (>=1)
POST_LINES, 1, idle lines between the last visible line and the vblank flag being set (>=1)
VBLANK_LINES, 20, lines spent in vblank before the pre-render line (>=1)
LINE_W, 9, width of y_idx and of the internal line counter; must hold max(VISIBLE_LINES, POST_LINES, VBLANK_LINES)-1

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-low reset
frame_start  in  1  one-cycle pulse from VGA timing marking the start of a frame
line_tick  in  1  one-cycle pulse once per scanline period
line_done  in  1  one-cycle pulse from the renderer when the requested line is finished
render_en  in  1  rendering enable (mask); when 0, timing runs but no render requests are issued
nmi_en  in  1  NMI enable
status_rd  in  1  one-cycle pulse when the CPU reads status; clears vblank_flag and underrun
render_start  out  1  one-cycle render request for line y_idx
y_idx  out  LINE_W  current visible line index; 0 outside VIS
phase  out  3  0=IDLE, 1=PRE, 2=VIS, 3=POST, 4=VBL
vblank_flag  out  1  status vblank bit
nmi  out  1  registered NMI level = vblank_flag & nmi_en
frame_odd  out  1  toggles at every entry into PRE from VBL or via resync
underrun  out  1  sticky: the renderer missed a line deadline

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; y_idx, line counter, render_start, vblank_flag, nmi, frame_odd, underrun and the pending flag are all 0. Reset mid-frame aborts the frame immediately.
- IDLE: ignores line_tick and line_done. On frame_start, the state is PRE on the next cycle. frame_odd does not toggle on this first entry.
- PRE: vblank_flag is cleared on entry. On line_tick: state goes to VIS with y_idx=0, and render_start=1 in the same cycle that phase first reads VIS (registered, 1-cycle latency from line_tick), if render_en.
- VIS, on line_tick:
  - Deadline check: if the pending flag is set, underrun<=1.
  - If y_idx==VISIBLE_LINES-1: go to POST, y_idx<=0, line counter<=0, no render_start.
  - Otherwise: y_idx<=y_idx+1, render_start pulses next cycle if render_en.
- Pending flag:
  - Set when render_start is issued; cleared by line_done.
  - A line_done with no pending request is ignored.
  - If line_done and line_tick occur in the same cycle, the line counts as done (no underrun).
- POST: counts line_ticks. On the POST_LINES-th tick, go to VBL and set vblank_flag<=1; line counter<=0.
- VBL: counts line_ticks. On the VBLANK_LINES-th tick, go to PRE and toggle frame_odd.
- Resync: frame_start in any non-IDLE state forces PRE next cycle, toggles frame_odd and clears the counter and the pending flag. It has priority over a same-cycle line_tick. No underrun is raised for the abandoned line.
- status_rd: vblank_flag<=0 and underrun<=0 next cycle. If the vblank flag is set (or an underrun is raised) in the same cycle, the set wins.
- nmi is registered from the next-state values of vblank_flag and nmi_en. Raising nmi_en while vblank_flag=1 asserts nmi one cycle later; status_rd or PRE entry drops it.
- render_en is sampled at line_tick. Dropping it mid-line does not cancel a request already issued.
- The line counter and y_idx never wrap beyond their parameter bounds.

Test Plan:
- Params VISIBLE_LINES=4, POST_LINES=1, VBLANK_LINES=2, render_en=1. Drive frame_start, then 8 line_ticks each 10 cycles apart, with line_done 3 cycles after every render_start -> phase sequence 1,2,2,2,2,3,4,4,1; render_start exactly 4 pulses with y_idx 0,1,2,3; vblank_flag=1 from the POST->VBL edge until PRE; frame_odd=1 at the final PRE; underrun=0.
- Same setup, but line_done is withheld for line 2 -> underrun=1 one cycle after the line_tick that ends line 2 and stays 1. A status_rd during VBL -> underrun=0 and vblank_flag=0 next cycle.
- render_en=0 for the whole frame -> no render_start pulses, identical phase/vblank timing, underrun=0.
- nmi_en=0 through the vblank set, then raised 5 cycles into VBL -> nmi=1 exactly 1 cycle after nmi_en rises; nmi falls 1 cycle after status_rd.
- status_rd in the same cycle as the POST->VBL line_tick -> vblank_flag=1 and nmi=1 (set wins).
- frame_start asserted in the same cycle as a line_tick while in VIS at y_idx=2 -> phase=1, y_idx=0, frame_odd toggled, no render_start, underrun unchanged. A subsequent reset=0 for one cycle -> all outputs 0, phase=0.
